// File: rtl/decode_pipe_if.sv
// decode_pipe_if -- bundles the upstream instruction handshake, the flush
// strobe and the downstream decoded-entry handshake of decode_pipe.
//
//   master : the environment side (drives i_*, observes o_*)
//   slave  : the decode_pipe side (observes i_*, drives o_*)
//
// Signals
//   i_valid / o_ready / i_instruction / i_pc : upstream instruction transfer
//   i_flush                                  : synchronous discard of all entries
//   o_valid / i_ready                        : downstream head-entry transfer
//   o_pc, rd_o .. o_illegal                  : decoded head entry (0 when !o_valid)
//   o_count                                  : occupied entries
interface decode_pipe_if #(
    parameter int N_param = 32,
    parameter int DEPTH   = 2
);
    logic                    i_valid;
    logic                    o_ready;
    logic [N_param-1:0]      i_instruction;
    logic [31:0]             i_pc;
    logic                    i_flush;
    logic                    o_valid;
    logic                    i_ready;
    logic [31:0]             o_pc;
    logic [4:0]              rd_o;
    logic [4:0]              rs1_o;
    logic [4:0]              rs2_o;
    logic [2:0]              fun3_o;
    logic [6:0]              fun7_o;
    logic [6:0]              opcode_o;
    logic [31:0]             imm_o;
    logic [6:0]              INST_typ_o;
    logic [63:0]             Single_Instruction_o;
    logic                    o_illegal;
    logic [$clog2(DEPTH):0]  o_count;

    modport master (
        output i_valid, i_instruction, i_pc, i_flush, i_ready,
        input  o_ready, o_valid, o_pc, rd_o, rs1_o, rs2_o, fun3_o, fun7_o,
               opcode_o, imm_o, INST_typ_o, Single_Instruction_o, o_illegal, o_count
    );

    modport slave (
        input  i_valid, i_instruction, i_pc, i_flush, i_ready,
        output o_ready, o_valid, o_pc, rd_o, rs1_o, rs2_o, fun3_o, fun7_o,
               opcode_o, imm_o, INST_typ_o, Single_Instruction_o, o_illegal, o_count
    );
endinterface

// File: rtl/decode_pipe.sv
// decode_pipe -- RV32I (+ optional M, optional Zicsr) instruction decoder
// followed by a DEPTH-entry FIFO of fully decoded records.
//
// Ports
//   i_clk : rising-edge clock
//   i_rst : asynchronous active-high reset; clears the FIFO immediately and
//           forces o_valid, o_ready and every data output low
//   bus   : decode_pipe_if.slave (handshakes, flush, decoded head entry)
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both 1 and i_flush is 0. o_ready depends only on the
// occupancy (never on i_ready), so a full buffer refuses a push even in a
// cycle where the head is popped. o_valid is high whenever an entry is held;
// the head entry stays stable until it is popped or flushed.
//
// Type codes (INST_typ_o): R=1 I=2 S=3 B=4 U=5 J=6 SYSTEM/FENCE=7,
// UNRECGONIZED=7'h7F. Single_Instruction_o is one-hot, bit index:
//   0 LUI 1 AUIPC 2 JAL 3 JALR 4..9 BEQ BNE BLT BGE BLTU BGEU
//   10..14 LB LH LW LBU LHU 15..17 SB SH SW
//   18..26 ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI
//   27..36 ADD SUB SLL SLT SLTU XOR SRL SRA OR AND
//   37 FENCE 38 ECALL 39 EBREAK 40..45 CSRRW CSRRS CSRRC CSRRWI CSRRSI CSRRCI
//   46..53 MUL MULH MULHSU MULHU DIV DIVU REM REMU 63 UNKNOWN
module decode_pipe #(
    parameter int N_param    = 32,
    parameter int DEPTH      = 2,
    parameter int ENABLE_M   = 0,
    parameter int ENABLE_CSR = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    decode_pipe_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [6:0] TYP_R = 7'd1, TYP_I = 7'd2, TYP_S = 7'd3, TYP_B = 7'd4;
    localparam logic [6:0] TYP_U = 7'd5, TYP_J = 7'd6, TYP_SYS = 7'd7, TYP_UNREC = 7'h7F;

    localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6F, OPC_JALR = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63, OPC_LOAD = 7'h03, OPC_STORE = 7'h23;
    localparam logic [6:0] OPC_OPIMM = 7'h13, OPC_OP = 7'h33, OPC_FENCE = 7'h0F, OPC_SYSTEM = 7'h73;

    localparam logic [5:0] IDX_LUI = 6'd0, IDX_AUIPC = 6'd1, IDX_JAL = 6'd2, IDX_JALR = 6'd3;
    localparam logic [5:0] IDX_BEQ = 6'd4, IDX_BNE = 6'd5, IDX_BLT = 6'd6, IDX_BGE = 6'd7;
    localparam logic [5:0] IDX_BLTU = 6'd8, IDX_BGEU = 6'd9;
    localparam logic [5:0] IDX_LB = 6'd10, IDX_LH = 6'd11, IDX_LW = 6'd12, IDX_LBU = 6'd13, IDX_LHU = 6'd14;
    localparam logic [5:0] IDX_SB = 6'd15, IDX_SH = 6'd16, IDX_SW = 6'd17;
    localparam logic [5:0] IDX_ADDI = 6'd18, IDX_SLTI = 6'd19, IDX_SLTIU = 6'd20, IDX_XORI = 6'd21;
    localparam logic [5:0] IDX_ORI = 6'd22, IDX_ANDI = 6'd23, IDX_SLLI = 6'd24, IDX_SRLI = 6'd25;
    localparam logic [5:0] IDX_SRAI = 6'd26;
    localparam logic [5:0] IDX_ADD = 6'd27, IDX_SUB = 6'd28, IDX_SLL = 6'd29, IDX_SLT = 6'd30;
    localparam logic [5:0] IDX_SLTU = 6'd31, IDX_XOR = 6'd32, IDX_SRL = 6'd33, IDX_SRA = 6'd34;
    localparam logic [5:0] IDX_OR = 6'd35, IDX_AND = 6'd36;
    localparam logic [5:0] IDX_FENCE = 6'd37, IDX_ECALL = 6'd38, IDX_EBREAK = 6'd39;
    localparam logic [5:0] IDX_CSRRW = 6'd40, IDX_CSRRS = 6'd41, IDX_CSRRC = 6'd42;
    localparam logic [5:0] IDX_CSRRWI = 6'd43, IDX_CSRRSI = 6'd44, IDX_CSRRCI = 6'd45;
    localparam logic [5:0] IDX_MUL = 6'd46, IDX_UNKNOWN = 6'd63;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  fun3;
        logic [6:0]  fun7;
        logic [6:0]  opcode;
        logic [31:0] imm;
        logic [6:0]  typ;
        logic [63:0] single;
        logic        illegal;
    } rec_t;

    // ---------------- combinational decode ----------------
    logic [31:0] ins;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [5:0]  sel;
    rec_t        dec;

    assign ins   = bus.i_instruction[31:0];
    assign op    = ins[6:0];
    assign f3    = ins[14:12];
    assign f7    = ins[31:25];
    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'b0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    always_comb begin
        dec     = '0;
        dec.typ = TYP_UNREC;
        sel     = IDX_UNKNOWN;
        case (op)
            OPC_LUI, OPC_AUIPC: begin
                dec.typ = TYP_U; dec.rd = ins[11:7]; dec.imm = imm_u;
                sel = (op == OPC_LUI) ? IDX_LUI : IDX_AUIPC;
            end
            OPC_JAL: begin
                dec.typ = TYP_J; dec.rd = ins[11:7]; dec.imm = imm_j; sel = IDX_JAL;
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                dec.typ = TYP_I; dec.rd = ins[11:7]; dec.fun3 = f3;
                dec.rs1 = ins[19:15]; dec.fun7 = f7; dec.imm = imm_i;
                if (op == OPC_JALR) begin
                    if (f3 == 3'b000) sel = IDX_JALR;
                end else if (op == OPC_LOAD) begin
                    case (f3)
                        3'b000:  sel = IDX_LB;
                        3'b001:  sel = IDX_LH;
                        3'b010:  sel = IDX_LW;
                        3'b100:  sel = IDX_LBU;
                        3'b101:  sel = IDX_LHU;
                        default: sel = IDX_UNKNOWN;
                    endcase
                end else begin
                    case (f3)
                        3'b000: sel = IDX_ADDI;
                        3'b010: sel = IDX_SLTI;
                        3'b011: sel = IDX_SLTIU;
                        3'b100: sel = IDX_XORI;
                        3'b110: sel = IDX_ORI;
                        3'b111: sel = IDX_ANDI;
                        // Shifts carry their variant in the upper immediate bits.
                        3'b001: sel = (f7 == 7'b0000000) ? IDX_SLLI : IDX_UNKNOWN;
                        3'b101: sel = (f7 == 7'b0000000) ? IDX_SRLI :
                                      (f7 == 7'b0100000) ? IDX_SRAI : IDX_UNKNOWN;
                    endcase
                end
            end
            OPC_STORE: begin
                dec.typ = TYP_S; dec.fun3 = f3; dec.rs1 = ins[19:15];
                dec.rs2 = ins[24:20]; dec.imm = imm_s;
                case (f3)
                    3'b000:  sel = IDX_SB;
                    3'b001:  sel = IDX_SH;
                    3'b010:  sel = IDX_SW;
                    default: sel = IDX_UNKNOWN;
                endcase
            end
            OPC_BRANCH: begin
                dec.typ = TYP_B; dec.fun3 = f3; dec.rs1 = ins[19:15];
                dec.rs2 = ins[24:20]; dec.imm = imm_b;
                case (f3)
                    3'b000:  sel = IDX_BEQ;
                    3'b001:  sel = IDX_BNE;
                    3'b100:  sel = IDX_BLT;
                    3'b101:  sel = IDX_BGE;
                    3'b110:  sel = IDX_BLTU;
                    3'b111:  sel = IDX_BGEU;
                    default: sel = IDX_UNKNOWN;
                endcase
            end
            OPC_OP: begin
                dec.typ = TYP_R; dec.rd = ins[11:7]; dec.fun3 = f3;
                dec.rs1 = ins[19:15]; dec.rs2 = ins[24:20]; dec.fun7 = f7;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000: sel = IDX_ADD;
                        3'b001: sel = IDX_SLL;
                        3'b010: sel = IDX_SLT;
                        3'b011: sel = IDX_SLTU;
                        3'b100: sel = IDX_XOR;
                        3'b101: sel = IDX_SRL;
                        3'b110: sel = IDX_OR;
                        3'b111: sel = IDX_AND;
                    endcase
                end else if (f7 == 7'b0100000) begin
                    if (f3 == 3'b000)      sel = IDX_SUB;
                    else if (f3 == 3'b101) sel = IDX_SRA;
                end else if (f7 == 7'b0000001 && ENABLE_M != 0) begin
                    // MUL..REMU are laid out in fun3 order.
                    sel = IDX_MUL + {3'b000, f3};
                end
            end
            OPC_FENCE, OPC_SYSTEM: begin
                dec.typ = TYP_SYS; dec.rd = ins[11:7]; dec.fun3 = f3;
                dec.rs1 = ins[19:15]; dec.rs2 = ins[24:20]; dec.fun7 = f7;
                dec.imm = imm_i;
                if (op == OPC_FENCE) begin
                    if (f3 == 3'b000) sel = IDX_FENCE;
                end else begin
                    case (f3)
                        3'b000: sel = (ins[31:20] == 12'd0) ? IDX_ECALL :
                                      (ins[31:20] == 12'd1) ? IDX_EBREAK : IDX_UNKNOWN;
                        3'b001: sel = (ENABLE_CSR != 0) ? IDX_CSRRW  : IDX_UNKNOWN;
                        3'b010: sel = (ENABLE_CSR != 0) ? IDX_CSRRS  : IDX_UNKNOWN;
                        3'b011: sel = (ENABLE_CSR != 0) ? IDX_CSRRC  : IDX_UNKNOWN;
                        3'b101: sel = (ENABLE_CSR != 0) ? IDX_CSRRWI : IDX_UNKNOWN;
                        3'b110: sel = (ENABLE_CSR != 0) ? IDX_CSRRSI : IDX_UNKNOWN;
                        3'b111: sel = (ENABLE_CSR != 0) ? IDX_CSRRCI : IDX_UNKNOWN;
                        default: sel = IDX_UNKNOWN;
                    endcase
                end
            end
            default: ;
        endcase
        // Recognised opcodes report their own opcode; unknown ones keep all fields 0.
        if (dec.typ != TYP_UNREC) dec.opcode = op;
        dec.pc      = bus.i_pc;
        dec.single  = 64'd1 << sel;
        dec.illegal = (sel == IDX_UNKNOWN);
    end

    // ---------------- decoded-entry FIFO ----------------
    rec_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;

    assign bus.o_ready = !i_rst && (count < CW'(DEPTH));
    assign bus.o_valid = !i_rst && (count != '0);
    assign bus.o_count = count;
    assign push = bus.i_valid && bus.o_ready && !bus.i_flush;
    assign pop  = bus.o_valid && bus.i_ready && !bus.i_flush;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        end
    end

    // Storage needs no reset: the outputs are gated by o_valid.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= dec;
    end

    rec_t head;
    assign head = bus.o_valid ? mem[rd_ptr] : '0;

    assign bus.o_pc                 = head.pc;
    assign bus.rd_o                 = head.rd;
    assign bus.rs1_o                = head.rs1;
    assign bus.rs2_o                = head.rs2;
    assign bus.fun3_o               = head.fun3;
    assign bus.fun7_o               = head.fun7;
    assign bus.opcode_o             = head.opcode;
    assign bus.imm_o                = head.imm;
    assign bus.INST_typ_o           = head.typ;
    assign bus.Single_Instruction_o = head.single;
    assign bus.o_illegal            = head.illegal;
endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 The block SHALL have parameter N_param, default 32, giving the instruction width.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the decoded-entry buffer depth (power of 2, >=2).
REQ-003 The block SHALL have parameter ENABLE_M, default 0; when 1, RV32M opcodes decode as legal.
REQ-004 The block SHALL have parameter ENABLE_CSR, default 1; when 1, CSR opcodes decode as legal.
REQ-005 The block SHALL have ports, one per line:
- i_clk  in  1  single clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  block can accept an instruction
- i_instruction  in  N_param  raw instruction
- i_pc  in  32  instruction address
- i_flush  in  1  synchronous discard of all buffered entries
- o_valid  out  1  head entry valid
- i_ready  in  1  downstream accepts head entry
- o_pc  out  32  head entry PC
- rd_o, rs1_o, rs2_o  out  5 each  register indices
- fun3_o  out  3; fun7_o  out  7; opcode_o  out  7
- imm_o  out  32  sign-extended immediate
- INST_typ_o  out  7  type code (INST_typ_* from params.vh)
- Single_Instruction_o  out  64  one-hot instruction code (inst_* from params.vh)
- o_illegal  out  1  head entry decoded as inst_UNKNOWN
- o_count  out  $clog2(DEPTH)+1  occupied entries

Function
REQ-006 The block SHALL decode i_instruction combinationally and write the full decoded record into the buffer tail on push = i_valid && o_ready && !i_flush.
REQ-007 The block SHALL drive o_ready = (o_count < DEPTH); a full buffer SHALL NOT accept, even with a same-cycle pop.
REQ-008 The block SHALL drive o_valid = (o_count != 0); pop = o_valid && i_ready && !i_flush.
REQ-009 Latency SHALL be one cycle: an entry pushed at edge N is visible at the outputs after edge N when the buffer was empty.
REQ-010 Entries SHALL leave in push order; pointers wrap modulo DEPTH; simultaneous push and pop SHALL leave o_count unchanged.
REQ-011 All data outputs (o_pc through o_illegal) SHALL read 0 while o_valid=0.
REQ-012 i_flush=1 SHALL, at the next edge, set o_count=0 and pointers to 0, discarding any same-cycle push and pop.
REQ-013 Field extraction: R: rd,fun3,rs1,rs2,fun7, imm=0; I (OP-IMM, LOAD, JALR): rd,fun3,rs1,fun7, rs2=0, imm=sext(inst[31:20]); S: fun3,rs1,rs2, imm=sext({inst[31:25],inst[11:7]}); B: fun3,rs1,rs2, imm=sext({inst[31],inst[7],inst[30:25],inst[11:8],0}); U: rd, imm={inst[31:12],12'b0}; J: rd, imm=sext({inst[31],inst[19:12],inst[20],inst[30:21],0}); SYSTEM/FENCE: all fields; unused fields 0.
REQ-014 Single_Instruction SHALL come from the same-cycle decode, never from a previous instruction's type.
REQ-015 SYSTEM fun3=000: inst[31:20]=0 -> inst_ECALL, =1 -> inst_EBREAK, other -> inst_UNKNOWN.
REQ-016 CSR fun3 (001,010,011,101,110,111) SHALL decode to inst_CSRR* when ENABLE_CSR=1, else inst_UNKNOWN.
REQ-017 OP with fun7=0000001 SHALL decode to inst_MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU by fun3 when ENABLE_M=1, else inst_UNKNOWN.
REQ-018 Unlisted opcode, fun3 or fun7 combinations SHALL yield inst_UNKNOWN and o_illegal=1; INST_typ for unknown opcodes SHALL be UNRECGONIZED with all fields 0.

Reset
REQ-019 i_rst=1 SHALL immediately, without a clock, clear buffer pointers and o_count, force o_valid=0, o_ready=0, and all data outputs to 0.
REQ-020 o_ready SHALL assert in the first cycle after i_rst deasserts; reset mid-stream SHALL discard buffered entries.

Verification
REQ-021 Push 0xFFF10093 with i_ready=1 -> next cycle o_valid=1, rd=1, rs1=2, imm=0xFFFFFFFF, inst_ADDI, o_illegal=0.
REQ-022 Hold i_ready=0 and push DEPTH instructions -> o_count=DEPTH, o_ready=0; release i_ready -> entries emerge in order with matching o_pc.
REQ-023 Full buffer, i_flush=1 with i_valid=1 -> next cycle o_count=0, o_valid=0, pushed instruction absent.
REQ-024 Push 0x022081B3 -> ENABLE_M=0: o_illegal=1, inst_UNKNOWN; ENABLE_M=1: inst_MUL, rd=3, rs1=1, rs2=2.
REQ-025 Push 0xFE000EE3, 0x00000073, 0x00100073 -> inst_BEQ imm=0xFFFFFFFC; inst_ECALL; inst_EBREAK.
REQ-026 Assert i_rst between clock edges with 2 entries buffered -> o_valid and o_count drop to 0 before the next edge.
